// File: rtl/capture_frame_writer.sv
// capture_frame_writer: synchronises the camera VSYNC/pixel strobe, waits for a
// clean frame start after arm, packs two 8-bit samples per 16-bit SPRAM word
// and writes them to a linear address range until end of frame or buffer full.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | after reset, waiting for arm
// S_WAIT_BLANK | armed, waiting for VSYNC high so we never start mid-frame
// S_WAIT_START | in vertical blanking, waiting for the VSYNC falling edge
// S_CAPTURE    | packing samples and writing words
// S_FLUSH      | one-cycle write of a dangling low-byte sample at frame end
// S_DONE       | capture finished, status held until the next arm
module capture_frame_writer #(
  parameter int MAX_WORDS = 16000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        vsync_in,
  input  logic        pixel_valid_in,
  input  logic [15:0] pixel_data_in,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [14:0] word_count,
  output logic        truncated
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BLANK,
    S_WAIT_START,
    S_CAPTURE,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [14:0] LP_MAX = 15'(MAX_WORDS);

  state_t      r_state;
  logic        r_vs_meta, r_vs_sync, r_vs_hist;
  logic        r_pv_meta, r_pv_sync, r_pv_hist;
  logic        r_wr_en;
  logic [13:0] r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_busy;
  logic        r_done;
  logic [14:0] r_word_count;
  logic        r_truncated;
  logic [7:0]  r_low;
  logic        r_have_low;

  logic        w_vs_rise;
  logic        w_vs_fall;
  logic        w_pv_rise;
  logic        w_full;
  logic [7:0]  w_sample;
  logic        w_unused_lo;

  assign w_vs_rise   = r_vs_sync & ~r_vs_hist;
  assign w_vs_fall   = ~r_vs_sync & r_vs_hist;
  assign w_pv_rise   = r_pv_sync & ~r_pv_hist;
  assign w_full      = (r_word_count == LP_MAX);
  // Only the top byte of RGB565 contributes to the sample.
  assign w_sample    = pixel_data_in[15:8];
  assign w_unused_lo = ^pixel_data_in[7:0];

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign word_count = r_word_count;
  assign truncated  = r_truncated;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_hist <= 1'b0;
      r_pv_meta <= 1'b0;
      r_pv_sync <= 1'b0;
      r_pv_hist <= 1'b0;
    end else begin
      r_vs_meta <= vsync_in;
      r_vs_sync <= r_vs_meta;
      r_vs_hist <= r_vs_sync;
      r_pv_meta <= pixel_valid_in;
      r_pv_sync <= r_pv_meta;
      r_pv_hist <= r_pv_sync;
    end
  end

  // Capture FSM with registered write port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 14'd0;
      r_wr_data    <= 16'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_count <= 15'd0;
      r_truncated  <= 1'b0;
      r_low        <= 8'd0;
      r_have_low   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            r_state      <= S_WAIT_BLANK;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_word_count <= 15'd0;
            r_truncated  <= 1'b0;
            r_have_low   <= 1'b0;
          end
        end
        S_WAIT_BLANK: begin
          if (r_vs_sync) r_state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (w_vs_fall) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // Full takes priority over end of frame: no flush once the buffer is used up.
          if (w_full) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_truncated <= ~r_vs_sync;
          end else if (w_vs_rise) begin
            if (r_have_low) begin
              r_wr_en      <= 1'b1;
              r_wr_addr    <= r_word_count[13:0];
              r_wr_data    <= {8'h00, r_low};
              r_word_count <= r_word_count + 15'd1;
              r_have_low   <= 1'b0;
              r_state      <= S_FLUSH;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else if (w_pv_rise) begin
            if (!r_have_low) begin
              r_low      <= w_sample;
              r_have_low <= 1'b1;
            end else begin
              r_wr_en      <= 1'b1;
              r_wr_addr    <= r_word_count[13:0];
              r_wr_data    <= {w_sample, r_low};
              r_word_count <= r_word_count + 15'd1;
              r_have_low   <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_frame_writer.sv
// Directed bench for capture_frame_writer: a default-size instance and a
// MAX_WORDS=4 instance share the camera inputs but have separate arm lines.
module tb_capture_frame_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        pv = 1'b0;
  logic [15:0] pdata = 16'd0;
  logic        arm_a = 1'b0;
  logic        arm_b = 1'b0;

  logic        a_wr_en, a_busy, a_done, a_trunc;
  logic [13:0] a_wr_addr;
  logic [15:0] a_wr_data;
  logic [14:0] a_wc;
  logic        b_wr_en, b_busy, b_done, b_trunc;
  logic [13:0] b_wr_addr;
  logic [15:0] b_wr_data;
  logic [14:0] b_wc;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [13:0] wa_addr [64];
  logic [15:0] wa_data [64];
  int          wa_cyc  [64];
  int          n_a = 0;
  logic [13:0] wb_addr [64];
  logic [15:0] wb_data [64];
  int          wb_cyc  [64];
  int          n_b = 0;
  logic        prev_done_a = 1'b0;
  logic        prev_done_b = 1'b0;
  int          done_rise_a = -1;
  int          done_rise_b = -1;

  capture_frame_writer dut_a (
    .clk(clk), .rst_n(rst_n), .arm(arm_a), .vsync_in(vsync),
    .pixel_valid_in(pv), .pixel_data_in(pdata),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .busy(a_busy), .done(a_done), .word_count(a_wc), .truncated(a_trunc)
  );

  capture_frame_writer #(.MAX_WORDS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .arm(arm_b), .vsync_in(vsync),
    .pixel_valid_in(pv), .pixel_data_in(pdata),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .busy(b_busy), .done(b_done), .word_count(b_wc), .truncated(b_trunc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write / done-edge logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (a_wr_en && n_a < 64) begin
      wa_addr[n_a] = a_wr_addr;
      wa_data[n_a] = a_wr_data;
      wa_cyc[n_a]  = cyc;
      n_a++;
    end
    if (b_wr_en && n_b < 64) begin
      wb_addr[n_b] = b_wr_addr;
      wb_data[n_b] = b_wr_data;
      wb_cyc[n_b]  = cyc;
      n_b++;
    end
    if (a_done && !prev_done_a) done_rise_a = cyc;
    if (b_done && !prev_done_b) done_rise_b = cyc;
    prev_done_a = a_done;
    prev_done_b = b_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] s);
    pdata = {s, ~s};
    pv = 1'b1;
    cyc_wait(3);
    pv = 1'b0;
    cyc_wait(3);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_wr_en"}, 32'(a_wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(a_wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(a_wr_data), 32'd0);
    check({tag, "_busy"}, 32'(a_busy), 32'd0);
    check({tag, "_done"}, 32'(a_done), 32'd0);
    check({tag, "_wc"}, 32'(a_wc), 32'd0);
    check({tag, "_trunc"}, 32'(a_trunc), 32'd0);
  endtask

  task automatic check_wa(input string tag, input int idx, input logic [13:0] ad, input logic [15:0] d);
    check({tag, "_addr"}, 32'(wa_addr[idx]), 32'(ad));
    check({tag, "_data"}, 32'(wa_data[idx]), 32'(d));
  endtask

  task automatic check_wb(input string tag, input int idx, input logic [13:0] ad, input logic [15:0] d);
    check({tag, "_addr"}, 32'(wb_addr[idx]), 32'(ad));
    check({tag, "_data"}, 32'(wb_data[idx]), 32'(d));
  endtask

  initial begin
    // Reset values
    cyc_wait(3);
    check_zero_a("rst");
    check("rst_b_busy", 32'(b_busy), 32'd0);
    rst_n = 1'b1;
    cyc_wait(3);

    // Arm mid-frame, pixels of the tail frame must be ignored
    arm_a = 1'b1;
    cyc_wait(1);
    arm_a = 1'b0;
    check("armA_busy", 32'(a_busy), 32'd1);
    pix(8'hEE);
    pix(8'hDD);
    pix(8'hCC);
    vsync = 1'b1;
    cyc_wait(10);
    check("midframe_no_wr", 32'(n_a), 32'd0);
    vsync = 1'b0;
    cyc_wait(5);
    for (int i = 1; i <= 6; i++) pix(8'(i * 8'h11));
    cyc_wait(3);
    vsync = 1'b1;
    cyc_wait(10);
    check("frameA_nwr", 32'(n_a), 32'd3);
    check_wa("frameA_w0", 0, 14'd0, 16'h2211);
    check_wa("frameA_w1", 1, 14'd1, 16'h4433);
    check_wa("frameA_w2", 2, 14'd2, 16'h6655);
    check("frameA_done", 32'(a_done), 32'd1);
    check("frameA_busy", 32'(a_busy), 32'd0);
    check("frameA_wc", 32'(a_wc), 32'd3);
    check("frameA_trunc", 32'(a_trunc), 32'd0);
    check("frameA_b_idle", 32'(n_b), 32'd0);

    // Re-arm from DONE, odd frame with a flushed tail and an ignored arm
    arm_a = 1'b1;
    cyc_wait(1);
    arm_a = 1'b0;
    check("rearm_busy", 32'(a_busy), 32'd1);
    check("rearm_done", 32'(a_done), 32'd0);
    check("rearm_wc", 32'(a_wc), 32'd0);
    cyc_wait(5);
    vsync = 1'b0;
    cyc_wait(5);
    pix(8'hA0);
    arm_a = 1'b1;
    cyc_wait(1);
    arm_a = 1'b0;
    pix(8'hB0);
    pix(8'hC0);
    cyc_wait(3);
    vsync = 1'b1;
    cyc_wait(10);
    check("odd_nwr", 32'(n_a), 32'd5);
    check_wa("odd_w0", 3, 14'd0, 16'hB0A0);
    check_wa("odd_flush", 4, 14'd1, 16'h00C0);
    check("odd_done_lat", 32'(done_rise_a), 32'(wa_cyc[4] + 1));
    check("odd_wc", 32'(a_wc), 32'd2);
    check("odd_trunc", 32'(a_trunc), 32'd0);

    // MAX_WORDS=4 instance, 20-pixel frame truncates after 4 words
    arm_b = 1'b1;
    cyc_wait(1);
    arm_b = 1'b0;
    cyc_wait(5);
    vsync = 1'b0;
    cyc_wait(5);
    for (int i = 1; i <= 10; i++) pix(8'(i));
    check("full_done_mid", 32'(b_done), 32'd1);
    for (int i = 11; i <= 20; i++) pix(8'(i));
    check("full_nwr", 32'(n_b), 32'd4);
    check_wb("full_w0", 0, 14'd0, 16'h0201);
    check_wb("full_w1", 1, 14'd1, 16'h0403);
    check_wb("full_w2", 2, 14'd2, 16'h0605);
    check_wb("full_w3", 3, 14'd3, 16'h0807);
    check("full_trunc", 32'(b_trunc), 32'd1);
    check("full_wc", 32'(b_wc), 32'd4);
    check("full_busy", 32'(b_busy), 32'd0);
    check("full_done_lat", 32'(done_rise_b), 32'(wb_cyc[3] + 1));
    check("full_a_untouched", 32'(n_a), 32'd5);
    vsync = 1'b1;
    cyc_wait(10);
    check("full_nwr_after", 32'(n_b), 32'd4);
    check("full_done_held", 32'(b_done), 32'd1);

    // Full and VSYNC rise detected in the same cycle: no flush, not truncated
    arm_b = 1'b1;
    cyc_wait(1);
    arm_b = 1'b0;
    check("sim_wc_clr", 32'(b_wc), 32'd0);
    cyc_wait(5);
    vsync = 1'b0;
    cyc_wait(5);
    for (int i = 1; i <= 7; i++) pix(8'(8'h20 + i));
    pdata = 16'h28D7;
    pv = 1'b1;
    cyc_wait(1);
    vsync = 1'b1;
    cyc_wait(2);
    pv = 1'b0;
    cyc_wait(10);
    check("sim_nwr", 32'(n_b), 32'd8);
    check_wb("sim_w0", 4, 14'd0, 16'h2221);
    check_wb("sim_w3", 7, 14'd3, 16'h2827);
    check("sim_trunc", 32'(b_trunc), 32'd0);
    check("sim_done", 32'(b_done), 32'd1);
    check("sim_wc", 32'(b_wc), 32'd4);

    // Asynchronous reset while a write strobe is in flight
    arm_a = 1'b1;
    cyc_wait(1);
    arm_a = 1'b0;
    cyc_wait(5);
    vsync = 1'b0;
    cyc_wait(5);
    for (int i = 1; i <= 9; i++) pix(8'(8'h30 + i));
    check("rstcap_nwr", 32'(n_a), 32'd9);
    check("rstcap_wc", 32'(a_wc), 32'd4);
    pdata = 16'h3AC5;
    pv = 1'b1;
    cyc_wait(2);
    #6;
    check("rstcap_wr_en_live", 32'(a_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_a("rstcap");
    cyc_wait(2);
    check("rstcap_dropped", 32'(n_a), 32'd9);
    rst_n = 1'b1;
    pv = 1'b0;
    cyc_wait(3);
    vsync = 1'b1;
    cyc_wait(8);
    vsync = 1'b0;
    cyc_wait(5);
    pix(8'h51);
    pix(8'h52);
    cyc_wait(3);
    check("postrst_nwr", 32'(n_a), 32'd9);
    check("postrst_busy", 32'(a_busy), 32'd0);
    check("postrst_done", 32'(a_done), 32'd0);
    check("postrst_wc", 32'(a_wc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
